// File: rtl/sub_bytes_enc_iter.sv
// Iterative forward AES SubBytes engine: substitutes LANES bytes of a 128-bit state per cycle
// through combinational S-box LUTs, with valid/ready handshakes on both sides.
module sub_bytes_enc_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_Clear,
  input  logic         i_Valid,
  input  logic [127:0] i_Din,
  output logic         o_Ready,
  output logic         o_Valid,
  output logic [127:0] o_Dout,
  input  logic         i_Ready,
  output logic         o_Busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gen_bad_lanes
    $error("sub_bytes_enc_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int unsigned Groups = 16 / LANES;
  localparam int unsigned CntW   = (Groups > 1) ? $clog2(Groups) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Groups - 1);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [10:0] top;
    top = 11'd2047 - {b, 3'b000};
    return SBox[top -: 8];
  endfunction

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          fsm_q, fsm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [127:0]    state_q, state_d;
  logic            ready_q, ready_d;

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (i_Clear) begin
      fsm_d = StIdle;
      cnt_d = '0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (i_Valid && ready_q) begin
            state_d = i_Din;
            cnt_d   = '0;
            fsm_d   = StBusy;
          end
        end
        StBusy: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            int unsigned pos;
            pos = 32'(cnt_q) * LANES + l;
            state_d[127 - 8*pos -: 8] = sbox_fwd(state_q[127 - 8*pos -: 8]);
          end
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            fsm_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (i_Ready) fsm_d = StIdle;
        end
        default: fsm_d = StIdle;
      endcase
    end
    // Registered so o_Ready is low during reset and rises on the first edge after release.
    ready_d = (fsm_d == StIdle);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      fsm_q   <= StIdle;
      cnt_q   <= '0;
      state_q <= '0;
      ready_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  assign o_Ready = ready_q;
  assign o_Valid = (fsm_q == StDone);
  assign o_Busy  = (fsm_q == StBusy);
  assign o_Dout  = state_q;

endmodule

// File: tb/tb_sub_bytes_enc_iter.sv
// Self-checking bench for sub_bytes_enc_iter: three instances (LANES 4, 1, 16) checked against
// a GF(2^8) inverse-plus-affine S-box model.
module tb_sub_bytes_enc_iter;

  logic                 clk;
  logic                 rst_n;
  logic [2:0]           clr, vld, rdyin;
  logic [2:0][127:0]    din;
  logic [2:0]           rdy, vout, bsy;
  logic [2:0][127:0]    dout;

  int vectors;
  int miscompares;

  sub_bytes_enc_iter #(.LANES(4)) u_dut4 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(clr[0]), .i_Valid(vld[0]), .i_Din(din[0]),
    .o_Ready(rdy[0]), .o_Valid(vout[0]), .o_Dout(dout[0]), .i_Ready(rdyin[0]), .o_Busy(bsy[0])
  );
  sub_bytes_enc_iter #(.LANES(1)) u_dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(clr[1]), .i_Valid(vld[1]), .i_Din(din[1]),
    .o_Ready(rdy[1]), .o_Valid(vout[1]), .o_Dout(dout[1]), .i_Ready(rdyin[1]), .o_Busy(bsy[1])
  );
  sub_bytes_enc_iter #(.LANES(16)) u_dut16 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(clr[2]), .i_Valid(vld[2]), .i_Din(din[2]),
    .o_Ready(rdy[2]), .o_Valid(vout[2]), .o_Dout(dout[2]), .i_Ready(rdyin[2]), .o_Busy(bsy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: S(x) = affine(x^-1) over GF(2^8) with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sbox_ref(s[127 - 8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one block on instance d, check busy/latency/result, then consume it.
  task automatic run_block(input int d, input logic [127:0] blk, input logic [127:0] exp,
                           input int lat, input string tag);
    int n;
    n = 0;
    while (!rdy[d] && n < 20) begin step(); n++; end
    check({tag, "_ready"}, 128'(rdy[d]), 128'(1));
    vld[d] = 1'b1;
    din[d] = blk;
    step();
    vld[d] = 1'b0;
    din[d] = rand128();
    n = 0;
    while (!vout[d] && n < 40) begin
      check({tag, "_busy"}, 128'(bsy[d]), 128'(1));
      step();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(lat));
    check({tag, "_dout"}, dout[d], exp);
    rdyin[d] = 1'b1;
    step();
    rdyin[d] = 1'b0;
    check({tag, "_valid_fall"}, 128'(vout[d]), 128'(0));
    check({tag, "_ready_back"}, 128'(rdy[d]), 128'(1));
  endtask

  localparam logic [127:0] FipsIn  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FipsOut = 128'hd42711aee0bf98f1b8b45de51e415230;

  initial begin
    logic [127:0] blk, held, a, b;
    int lat_tab[3];
    int acc_q[$];
    logic [127:0] out_q[$];
    int cyc, sent;

    vectors = 0;
    miscompares = 0;
    lat_tab[0] = 4; lat_tab[1] = 16; lat_tab[2] = 1;
    rst_n = 1'b0; clr = '0; vld = '0; rdyin = '0; din = '0;

    // Reset state
    #1;
    check("rst_ready", 128'(rdy), 128'(0));
    check("rst_valid", 128'(vout), 128'(0));
    check("rst_busy", 128'(bsy), 128'(0));
    check("rst_dout", dout[0] | dout[1] | dout[2], 128'h0);
    step();
    check("rst_hold_ready", 128'(rdy), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rel_ready", 128'(rdy), 128'(3'b111));

    // FIPS-197 vector
    run_block(0, FipsIn, FipsOut, 4, "fips4");

    // Corner bytes and random blocks on every LANES value
    for (int d = 0; d < 3; d++) begin
      run_block(d, 128'h0, {16{8'h63}}, lat_tab[d], $sformatf("zero_d%0d", d));
      run_block(d, {16{8'h52}}, 128'h0, lat_tab[d], $sformatf("x52_d%0d", d));
      run_block(d, {4{32'h000153ff}}, {4{32'h637ced16}}, lat_tab[d], $sformatf("pat_d%0d", d));
      run_block(d, FipsIn, FipsOut, lat_tab[d], $sformatf("fips_d%0d", d));
      for (int r = 0; r < 2; r++) begin
        blk = rand128();
        run_block(d, blk, ref_sub(blk), lat_tab[d], $sformatf("rand_d%0d_%0d", d, r));
      end
    end

    // Backpressure
    blk = rand128();
    vld[0] = 1'b1; din[0] = blk;
    step();
    din[0] = rand128();
    cyc = 0;
    while (!vout[0] && cyc < 40) begin step(); cyc++; end
    check("bp_lat", 128'(cyc), 128'(4));
    held = dout[0];
    check("bp_dout", held, ref_sub(blk));
    for (int i = 0; i < 10; i++) begin
      din[0] = rand128();
      step();
      check($sformatf("bp_valid_%0d", i), 128'(vout[0]), 128'(1));
      check($sformatf("bp_stable_%0d", i), dout[0], held);
      check($sformatf("bp_ready_%0d", i), 128'(rdy[0]), 128'(0));
    end
    vld[0] = 1'b0;
    rdyin[0] = 1'b1;
    step();
    rdyin[0] = 1'b0;
    check("bp_valid_fall", 128'(vout[0]), 128'(0));
    check("bp_ready_back", 128'(rdy[0]), 128'(1));

    // Back-to-back
    a = rand128();
    b = rand128();
    vld[0] = 1'b1; din[0] = a; rdyin[0] = 1'b1;
    cyc = 0; sent = 0;
    for (int i = 0; i < 30; i++) begin
      if (rdy[0] && vld[0]) begin acc_q.push_back(cyc); sent++; end
      if (vout[0] && rdyin[0]) out_q.push_back(dout[0]);
      step();
      cyc++;
      if (sent == 1) din[0] = b;
      if (sent == 2) vld[0] = 1'b0;
    end
    rdyin[0] = 1'b0;
    check("b2b_accepts", 128'(acc_q.size()), 128'(2));
    check("b2b_results", 128'(out_q.size()), 128'(2));
    if (acc_q.size() == 2) check("b2b_interval", 128'(acc_q[1] - acc_q[0]), 128'(6));
    if (out_q.size() == 2) begin
      check("b2b_first", out_q[0], ref_sub(a));
      check("b2b_second", out_q[1], ref_sub(b));
    end

    // Flush on BUSY cycle 2
    vld[0] = 1'b1; din[0] = rand128();
    step();
    vld[0] = 1'b0;
    step();
    check("flush_busy_pre", 128'(bsy[0]), 128'(1));
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    check("flush_idle_busy", 128'(bsy[0]), 128'(0));
    check("flush_idle_ready", 128'(rdy[0]), 128'(1));
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("flush_no_valid_%0d", i), 128'(vout[0]), 128'(0));
    end
    clr[0] = 1'b1; vld[0] = 1'b1; din[0] = rand128();
    step();
    clr[0] = 1'b0; vld[0] = 1'b0;
    check("clr_vld_busy", 128'(bsy[0]), 128'(0));
    check("clr_vld_ready", 128'(rdy[0]), 128'(1));
    blk = rand128();
    run_block(0, blk, ref_sub(blk), 4, "post_flush");

    // Asynchronous reset mid-operation
    vld[0] = 1'b1; din[0] = rand128();
    step();
    vld[0] = 1'b0;
    check("mrst_busy_pre", 128'(bsy[0]), 128'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst_dout", dout[0], 128'h0);
    check("mrst_busy", 128'(bsy[0]), 128'(0));
    check("mrst_valid", 128'(vout[0]), 128'(0));
    check("mrst_ready", 128'(rdy[0]), 128'(0));
    step();
    check("mrst_hold_ready", 128'(rdy[0]), 128'(0));
    check("mrst_hold_valid", 128'(vout[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mrst_rel_ready", 128'(rdy[0]), 128'(1));
    check("mrst_rel_valid", 128'(vout[0]), 128'(0));
    run_block(0, FipsIn, FipsOut, 4, "fips_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
